// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter over four valid/ready requesters with a one-deep registered
// output slot; out_sel exports the granted index for downstream 4:1 mux select.
//
// state | meaning
// EMPTY | output slot holds no item (out_valid=0)
// FULL  | output slot holds an item waiting for out_ready (out_valid=1)
module rr_mux_arbiter_4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   out_sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   last;
  logic [1:0]   grant;
  logic [1:0]   idx;
  logic         load_en;
  logic         take;
  logic [W-1:0] data_sel;

  assign out_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    grant     = 2'd0;
    idx       = 2'd0;
    req_ready = 4'b0000;
    data_sel  = '0;
    load_en   = !out_valid || out_ready;
    // Walk from farthest to nearest so the nearest requester after last wins.
    for (int k = 3; k >= 0; k--) begin
      idx = last + 2'(k + 1);
      if (req_valid[idx]) begin
        grant = idx;
      end
    end
    // rst gates ready so no requester sees an accept while state is being cleared.
    take = load_en && (|req_valid) && !rst;
    if (take) begin
      req_ready[grant] = 1'b1;
    end
    case (grant)
      2'd0:    data_sel = d0;
      2'd1:    data_sel = d1;
      2'd2:    data_sel = d2;
      default: data_sel = d3;
    endcase
    case (state)
      EMPTY: if (take) state_nxt = FULL;
      FULL:  if (out_ready && !take) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= 2'd0;
      last     <= 2'd3;
    end else begin
      state <= state_nxt;
      if (take) begin
        out_data <= data_sel;
        out_sel  <= grant;
        last     <= grant;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4: round-robin order, backpressure hold,
// sparse requests, wrap fairness and asynchronous reset.
module tb_rr_mux_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic [3:0] d0, d1, d2, d3;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_sel;

  int n_chk;
  int n_bad;

  rr_mux_arbiter_4 #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] s, input logic [3:0] d);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".sel"},   32'(out_sel),   32'(s));
    check({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  logic [1:0] rr_sel [5]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rr_data [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
  logic [3:0] rr_rdy [5]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b0;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    #3;
    check("rst.ready", 32'(req_ready), 32'(4'b0000));
    check_out("rst", 1'b0, 2'd0, 4'h0);
    #9;
    rst = 1'b0;
    req_valid = 4'b0000;
    cyc();
    check_out("idle", 1'b0, 2'd0, 4'h0);
    check("idle.ready", 32'(req_ready), 32'(4'b0000));

    // Round robin across all four
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("rr.ready0", 32'(req_ready), 32'(4'b0001));
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_out($sformatf("rr%0d", i), 1'b1, rr_sel[i], rr_data[i]);
      check($sformatf("rr%0d.ready", i), 32'(req_ready), 32'(rr_rdy[i]));
    end

    // Backpressure with req 2 captured
    cyc();
    check_out("bp.pre", 1'b1, 2'd1, 4'h2);
    d2 = 4'hA;
    cyc();
    check_out("bp.cap", 1'b1, 2'd2, 4'hA);
    out_ready = 1'b0;
    #1;
    check("bp.ready", 32'(req_ready), 32'(4'b0000));
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_out($sformatf("bp%0d", i), 1'b1, 2'd2, 4'hA);
      check($sformatf("bp%0d.ready", i), 32'(req_ready), 32'(4'b0000));
    end
    out_ready = 1'b1;
    d3 = 4'h7;
    #1;
    check("bp.release", 32'(req_ready), 32'(4'b1000));
    cyc();
    check_out("bp.after", 1'b1, 2'd3, 4'h7);

    // Sparse: only req 1, then only req 3, then a gap
    req_valid = 4'b0010;
    d1 = 4'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("sp%0d.ready", i), 32'(req_ready), 32'(4'b0010));
      cyc();
      check_out($sformatf("sp%0d", i), 1'b1, 2'd1, 4'h5);
    end
    req_valid = 4'b1000;
    d3 = 4'h9;
    cyc();
    check_out("sp3", 1'b1, 2'd3, 4'h9);
    req_valid = 4'b0000;
    #1;
    check("gap.ready", 32'(req_ready), 32'(4'b0000));
    cyc();
    check_out("gap", 1'b0, 2'd3, 4'h9);
    cyc();
    check_out("gap2", 1'b0, 2'd3, 4'h9);

    // Fairness after wrap: last=3, req 0 and 3 pending
    req_valid = 4'b1001;
    d0 = 4'h6;
    d3 = 4'h8;
    #1;
    check("fair.ready0", 32'(req_ready), 32'(4'b0001));
    cyc();
    check_out("fair0", 1'b1, 2'd0, 4'h6);
    check("fair.ready1", 32'(req_ready), 32'(4'b1000));
    cyc();
    check_out("fair1", 1'b1, 2'd3, 4'h8);

    // Reset mid-hold
    req_valid = 4'b1111;
    out_ready = 1'b0;
    cyc();
    check_out("hold", 1'b1, 2'd3, 4'h8);
    #2;
    rst = 1'b1;
    #1;
    check_out("mrst", 1'b0, 2'd0, 4'h0);
    check("mrst.ready", 32'(req_ready), 32'(4'b0000));
    rst = 1'b0;
    #1;
    check("post.ready", 32'(req_ready), 32'(4'b0001));
    cyc();
    check_out("post", 1'b1, 2'd0, 4'h6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
